ex_alu_stage: RTL and testbench

EX_ALU_STAGE -- requirements
Module: ex_alu_stage

---
 rtl/ex_alu_stage_pkg.sv | 39 +++
 rtl/ex_alu_stage_alu.sv | 36 +++
 rtl/ex_alu_stage.sv | 182 ++++++++++++++++++
 tb/tb_ex_alu_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_alu_stage_pkg.sv
// Shared instruction types: ALU operation codes and branch kinds.
// Imported by the ALU and the execute stage.
package instruction_types;

    localparam int XLEN = 32;

    // ALU operation codes; codes above ALU_AND are unused
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_t;

    // Control-flow kind of the instruction in EX
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BEQ     = 4'd1,
        BNE     = 4'd2,
        BLT     = 4'd3,
        BGE     = 4'd4,
        BLTU    = 4'd5,
        BGEU    = 4'd6,
        JAL     = 4'd7,
        JALR    = 4'd8
    } branch_t;

    // True for codes the ALU actually implements
    function automatic logic alu_op_valid(input logic [3:0] op);
        return op <= ALU_AND;
    endfunction

endpackage

// File: rtl/ex_alu_stage_alu.sv
// Combinational 32-bit ALU.
// Unimplemented op codes produce zero.
module alu
    import instruction_types::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      op_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    // Operation select
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'd0, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU, branch resolution, EX/MEM register, fetch redirect.
// Optional macro EX_FORWARD_EN enables EX->EX operand forwarding.
module ex_alu_stage
    import instruction_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1_idx,
    input  logic [4:0]  in_rs2_idx,
    input  logic [3:0]  in_alu_op,
    input  logic        in_a_sel,
    input  logic        in_b_sel,
    input  logic [3:0]  in_br,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_result_q, out_result_d;
    logic [4:0]  out_rd_q;
    logic        out_wen_q, out_wen_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        accept;
    logic [31:0] rs1_v, rs2_v;
    logic [31:0] op_a, op_b;
    logic [3:0]  op_sel;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        is_cond, is_jump, taken;
    logic        rd_nz;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

`ifdef EX_FORWARD_EN
    logic fwd_src, fwd1, fwd2;
    assign fwd_src = out_valid_q && out_wen_q && (out_rd_q != 5'd0);
    assign fwd1    = fwd_src && (in_rs1_idx == out_rd_q);
    assign fwd2    = fwd_src && (in_rs2_idx == out_rd_q);
    assign rs1_v   = fwd1 ? out_result_q : in_rs1;
    assign rs2_v   = fwd2 ? out_result_q : in_rs2;
`else
    logic unused_idx;
    assign unused_idx = ^{in_rs1_idx, in_rs2_idx};
    assign rs1_v      = in_rs1;
    assign rs2_v      = in_rs2;
`endif

    // Operand and ALU-op selection; compares force their own op on rs1/rs2
    always_comb begin
        op_sel  = in_alu_op;
        op_a    = in_a_sel ? in_pc : rs1_v;
        op_b    = in_b_sel ? in_imm : rs2_v;
        is_cond = 1'b0;
        is_jump = 1'b0;
        case (in_br)
            BEQ, BNE: begin
                op_sel  = ALU_SUB;
                op_a    = rs1_v;
                op_b    = rs2_v;
                is_cond = 1'b1;
            end
            BLT, BGE: begin
                op_sel  = ALU_SLT;
                op_a    = rs1_v;
                op_b    = rs2_v;
                is_cond = 1'b1;
            end
            BLTU, BGEU: begin
                op_sel  = ALU_SLTU;
                op_a    = rs1_v;
                op_b    = rs2_v;
                is_cond = 1'b1;
            end
            JAL, JALR: is_jump = 1'b1;
            default: ;
        endcase
    end

    alu u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .op_i     (op_sel),
        .result_o (alu_res),
        .zero_o   (alu_zero)
    );

    // Branch decision from the ALU compare result
    always_comb begin
        taken = 1'b0;
        case (in_br)
            BEQ:        taken = alu_zero;
            BNE:        taken = !alu_zero;
            BLT, BLTU:  taken = alu_res[0];
            BGE, BGEU:  taken = !alu_res[0];
            JAL, JALR:  taken = 1'b1;
            default:    taken = 1'b0;
        endcase
    end

    assign rd_nz = (in_rd != 5'd0);

    // Result, writeback enable and redirect target for the incoming item
    always_comb begin
        out_result_d = alu_op_valid(op_sel) ? alu_res : 32'd0;
        out_wen_d    = in_wen && rd_nz;
        redir_pc_d   = in_pc + in_imm;
        if (is_jump) begin
            out_result_d = in_pc + 32'd4;
        end
        if (is_cond) begin
            out_wen_d = 1'b0;
        end
        if (in_br == JALR) begin
            redir_pc_d = (rs1_v + in_imm) & ~32'd1;
        end
    end

    // Handshake: flush wins, then accept, then drain
    always_comb begin
        out_valid_d   = out_valid_q;
        redir_valid_d = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            redir_valid_d = taken;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Control flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            redir_valid_q <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            redir_valid_q <= redir_valid_d;
        end
    end

    // EX/MEM payload, loaded only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_wen_q    <= 1'b0;
            redir_pc_q   <= '0;
        end else if (accept) begin
            out_result_q <= out_result_d;
            out_rd_q     <= in_rd;
            out_wen_q    <= out_wen_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_rd         = out_rd_q;
    assign out_wen        = out_wen_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed test of ex_alu_stage: vector table plus handshake,
// flush, reset and forwarding sequences.
module tb_ex_alu_stage;
    import instruction_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [4:0]  in_rs1_idx, in_rs2_idx;
    logic [3:0]  in_alu_op;
    logic        in_a_sel, in_b_sel;
    logic [3:0]  in_br;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_alu_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_imm         (in_imm),
        .in_rs1_idx     (in_rs1_idx),
        .in_rs2_idx     (in_rs2_idx),
        .in_alu_op      (in_alu_op),
        .in_a_sel       (in_a_sel),
        .in_b_sel       (in_b_sel),
        .in_br          (in_br),
        .in_rd          (in_rd),
        .in_wen         (in_wen),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_wen        (out_wen),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [3:0]  br;
        logic [3:0]  op;
        logic        a_sel;
        logic        b_sel;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] e_res;
        logic        chk_res;
        logic        e_wen;
        logic        e_redir;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [3:0] br, input logic [3:0] op,
        input logic a_sel, input logic b_sel,
        input logic [31:0] pc, input logic [31:0] rs1,
        input logic [31:0] rs2, input logic [31:0] imm,
        input logic [4:0] rd, input logic wen,
        input logic [31:0] e_res, input logic chk_res,
        input logic e_wen, input logic e_redir,
        input logic [31:0] e_rpc);
        vec_t v;
        v.br = br; v.op = op; v.a_sel = a_sel; v.b_sel = b_sel;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.rd = rd; v.wen = wen; v.e_res = e_res; v.chk_res = chk_res;
        v.e_wen = e_wen; v.e_redir = e_redir; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_br     = v.br;
        in_alu_op = v.op;
        in_a_sel  = v.a_sel;
        in_b_sel  = v.b_sel;
        in_pc     = v.pc;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
        in_rd     = v.rd;
        in_wen    = v.wen;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pc      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_imm     = '0;
        in_rs1_idx = '0;
        in_rs2_idx = '0;
        in_alu_op  = '0;
        in_a_sel   = 1'b0;
        in_b_sel   = 1'b0;
        in_br      = '0;
        in_rd      = '0;
        in_wen     = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;

        // br, op, asel, bsel, pc, rs1, rs2, imm, rd, wen,
        // e_res, chk_res, e_wen, e_redir, e_rpc
        vecs.push_back(mk(BR_NONE, ALU_ADD, 0, 0, 32'h0, 32'd5, 32'd7, 32'h0,
                          5'd3, 1, 32'd12, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_SUB, 0, 0, 32'h0, 32'd5, 32'd7, 32'h0,
                          5'd4, 1, 32'hFFFF_FFFE, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_SLT, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0,
                          5'd5, 1, 32'd1, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_SLTU, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0,
                          5'd5, 1, 32'd0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_SRA, 0, 0, 32'h0, 32'h8000_0000, 32'd4, 32'h0,
                          5'd6, 1, 32'hF800_0000, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_SRL, 0, 0, 32'h0, 32'h8000_0000, 32'd4, 32'h0,
                          5'd6, 1, 32'h0800_0000, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_SLL, 0, 0, 32'h0, 32'd1, 32'd31, 32'h0,
                          5'd7, 1, 32'h8000_0000, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_XOR, 0, 0, 32'h0, 32'hF0F0, 32'h0FF0, 32'h0,
                          5'd8, 1, 32'hFF00, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_OR, 0, 0, 32'h0, 32'hF0F0, 32'h0FF0, 32'h0,
                          5'd8, 1, 32'hFFF0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_AND, 0, 0, 32'h0, 32'hF0F0, 32'h0FF0, 32'h0,
                          5'd8, 1, 32'h00F0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_ADD, 0, 0, 32'h0, 32'd1, 32'd1, 32'h0,
                          5'd0, 1, 32'd2, 1, 0, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, ALU_ADD, 1, 1, 32'h100, 32'd9, 32'd9, 32'h10,
                          5'd9, 0, 32'h110, 1, 0, 0, 32'h0));
        vecs.push_back(mk(BR_NONE, 4'd12, 0, 0, 32'h0, 32'd3, 32'd4, 32'h0,
                          5'd10, 1, 32'd0, 1, 1, 0, 32'h0));
        vecs.push_back(mk(BNE, ALU_ADD, 0, 0, 32'h100, 32'd9, 32'd9, 32'h20,
                          5'd1, 1, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(BNE, ALU_ADD, 0, 0, 32'h100, 32'd9, 32'd8, 32'h20,
                          5'd1, 1, 32'h0, 0, 0, 1, 32'h120));
        vecs.push_back(mk(BEQ, ALU_ADD, 0, 0, 32'h200, 32'd4, 32'd4, 32'hFFFF_FFF8,
                          5'd1, 1, 32'h0, 0, 0, 1, 32'h1F8));
        vecs.push_back(mk(BLT, ALU_ADD, 0, 0, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h8,
                          5'd1, 0, 32'h0, 0, 0, 1, 32'h308));
        vecs.push_back(mk(BGE, ALU_ADD, 0, 0, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h8,
                          5'd1, 0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(BLTU, ALU_ADD, 0, 0, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h8,
                          5'd1, 0, 32'h0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(BGEU, ALU_ADD, 0, 0, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h8,
                          5'd1, 0, 32'h0, 0, 0, 1, 32'h308));
        vecs.push_back(mk(JAL, ALU_ADD, 0, 0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h10,
                          5'd1, 1, 32'h0, 1, 1, 1, 32'h0000_000C));
        vecs.push_back(mk(JAL, ALU_ADD, 0, 0, 32'h80, 32'd0, 32'd0, 32'h10,
                          5'd0, 1, 32'h84, 1, 0, 1, 32'h90));
        vecs.push_back(mk(JALR, ALU_ADD, 0, 1, 32'h40, 32'h1001, 32'd0, 32'h4,
                          5'd1, 1, 32'h44, 1, 1, 1, 32'h1004));

        // Reset state
        step();
        step();
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out_wen", {31'd0, out_wen}, 32'd0);
        chk("rst.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst.out_result", out_result, 32'd0);
        chk("rst.out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back vectors, one per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
            if (vecs[i].chk_res)
                chk($sformatf("v%0d.out_result", i), out_result, vecs[i].e_res);
            chk($sformatf("v%0d.out_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d.out_wen", i), {31'd0, out_wen}, {31'd0, vecs[i].e_wen});
            chk($sformatf("v%0d.redirect_valid", i), {31'd0, redirect_valid},
                {31'd0, vecs[i].e_redir});
            if (vecs[i].e_redir)
                chk($sformatf("v%0d.redirect_pc", i), redirect_pc, vecs[i].e_rpc);
        end

        // Drain: redirect lasts one cycle, valid clears
        in_valid = 1'b0;
        step();
        chk("drain.out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain.redirect_valid", {31'd0, redirect_valid}, 32'd0);

        // Flush concurrent with a taken BEQ
        drive(mk(BEQ, ALU_ADD, 0, 0, 32'h500, 32'd3, 32'd3, 32'h40,
                 5'd2, 0, 32'h0, 0, 0, 1, 32'h540));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush.redirect_valid", {31'd0, redirect_valid}, 32'd0);

        // Flush kills a held result
        drive(mk(BR_NONE, ALU_ADD, 0, 0, 32'h0, 32'd2, 32'd2, 32'h0,
                 5'd2, 1, 32'd4, 1, 1, 0, 32'h0));
        step();
        chk("flush2.pre_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("flush2.out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: hold 3 cycles, then release
        drive(mk(BR_NONE, ALU_ADD, 0, 0, 32'h0, 32'd1, 32'd2, 32'h0,
                 5'd7, 1, 32'd3, 1, 1, 0, 32'h0));
        step();
        chk("stall.a_result", out_result, 32'd3);
        out_ready = 1'b0;
        drive(mk(BR_NONE, ALU_ADD, 0, 0, 32'h0, 32'd10, 32'd20, 32'h0,
                 5'd8, 1, 32'd30, 1, 1, 0, 32'h0));
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
            step();
            chk($sformatf("stall%0d.out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d.out_result", c), out_result, 32'd3);
            chk($sformatf("stall%0d.out_rd", c), {27'd0, out_rd}, 32'd7);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("release.out_result", out_result, 32'd30);
        chk("release.out_rd", {27'd0, out_rd}, 32'd8);
        in_valid = 1'b0;
        step();

        // Forwarding from the EX/MEM register
        drive(mk(BR_NONE, ALU_ADD, 0, 0, 32'h0, 32'd5, 32'd7, 32'h0,
                 5'd5, 1, 32'd12, 1, 1, 0, 32'h0));
        step();
        chk("fwd.first", out_result, 32'd12);
        drive(mk(BR_NONE, ALU_ADD, 0, 1, 32'h0, 32'd0, 32'd0, 32'd1,
                 5'd6, 1, 32'd0, 1, 1, 0, 32'h0));
        in_rs1_idx = 5'd5;
        step();
        in_rs1_idx = 5'd0;
`ifdef EX_FORWARD_EN
        chk("fwd.second", out_result, 32'd13);
`else
        chk("fwd.second", out_result, 32'd1);
`endif

        // Reset mid-transfer discards the held result at once
        drive(mk(BR_NONE, ALU_ADD, 0, 0, 32'h0, 32'd40, 32'd2, 32'h0,
                 5'd9, 1, 32'd42, 1, 1, 0, 32'h0));
        step();
        chk("midrst.pre_result", out_result, 32'd42);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst.out_result", out_result, 32'd0);
        chk("midrst.out_wen", {31'd0, out_wen}, 32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
